// File: rtl/alu_sweep_checker_if.sv
// Bus between the sweep checker and the 4-bit ALU it exercises.
// The checker drives operand/select bits and samples the four result bits.
interface alu_sweep_checker_if;
    logic op_a;
    logic op_b;
    logic op_c;
    logic op_d;
    logic sel_s0;
    logic sel_s1;
    logic res_a;
    logic res_b;
    logic res_c;
    logic res_d;

    modport master (
        output op_a, op_b, op_c, op_d, sel_s0, sel_s1,
        input  res_a, res_b, res_c, res_d
    );

    modport slave (
        input  op_a, op_b, op_c, op_d, sel_s0, sel_s1,
        output res_a, res_b, res_c, res_d
    );
endinterface

// File: rtl/alu_sweep_checker.sv
// On-chip self-test for the 4-bit ALU: sweeps all 64 {select,operand} vectors,
// compares each result against a golden model, and reports mismatch statistics.
//
// state  | meaning
// IDLE   | waiting for start
// DRIVE  | register operand/select from the vector index
// SETTLE | wait SETTLE_CYCLES for the ALU outputs to settle
// CHECK  | sample and compare ALU results, advance index
// DONE   | one-cycle completion pulse
module alu_sweep_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter bit STOP_ON_ERR   = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    alu_sweep_checker_if.master         alu,
    output logic                        busy,
    output logic                        done,
    output logic [6:0]                  err_count,
    output logic                        first_err_vld,
    output logic [5:0]                  first_err_vec
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      idx_q, idx_d;
    logic [3:0]      op_q, op_d;
    logic [1:0]      sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      err_q, err_d;
    logic            fvld_q, fvld_d;
    logic [5:0]      fvec_q, fvec_d;

    logic [3:0]      res_vec;
    logic [3:0]      golden_vec;
    logic            mismatch;

    function automatic logic [3:0] golden(input logic [3:0] x, input logic [1:0] s);
        logic [3:0] g;
        g = x;
        case (s)
            2'b00: g = x;
            2'b01: g = ~x + 4'd1;
            2'b10: begin
                // arithmetic shift floors; odd negatives need +1 to truncate toward zero
                g = {x[3], x[3:1]};
                if (x[3] && x[0]) g = g + 4'd1;
            end
            2'b11: g = x % 4'd3;
            default: g = x;
        endcase
        return g;
    endfunction

    assign res_vec    = {alu.res_a, alu.res_b, alu.res_c, alu.res_d};
    assign golden_vec = golden(op_q, sel_q);
    assign mismatch   = (state_q == S_CHECK) && (res_vec != golden_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fvld_q  <= 1'b0;
            fvec_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fvld_q  <= fvld_d;
            fvec_q  <= fvec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fvld_d  = fvld_q;
        fvec_d  = fvec_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    err_d   = '0;
                    fvld_d  = 1'b0;
                    fvec_d  = '0;
                end
            end
            S_DRIVE: begin
                op_d  = idx_q[3:0];
                sel_d = idx_q[5:4];
                if (SETTLE_CYCLES == 0) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_SETTLE;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_CHECK;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 7'd1;
                    if (!fvld_q) begin
                        fvld_d = 1'b1;
                        fvec_d = idx_q;
                    end
                end
                if ((idx_q == 6'd63) || (STOP_ON_ERR && mismatch)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_DRIVE, S_SETTLE, S_CHECK: busy = 1'b1;
            S_DONE:                     done = 1'b1;
            default: ;
        endcase
    end

    assign alu.op_a      = op_q[3];
    assign alu.op_b      = op_q[2];
    assign alu.op_c      = op_q[1];
    assign alu.op_d      = op_q[0];
    assign alu.sel_s0    = sel_q[1];
    assign alu.sel_s1    = sel_q[0];
    assign err_count     = err_q;
    assign first_err_vld = fvld_q;
    assign first_err_vec = fvec_q;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Bench for alu_sweep_checker: three checker instances (default, stop-on-error,
// zero settle) each beside a reference ALU with an optional stuck-at-0 on res_d.
module tb_alu_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v = 3'b000;
    logic       fault = 1'b0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    alu_sweep_checker_if alu0 ();
    alu_sweep_checker_if alu1 ();
    alu_sweep_checker_if alu2 ();

    logic [2:0] busy_v, done_v, vld_v;
    logic [6:0] ec_v [3];
    logic [5:0] vec_v [3];

    alu_sweep_checker #(.SETTLE_CYCLES(2), .STOP_ON_ERR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .alu(alu0.master),
        .busy(busy_v[0]), .done(done_v[0]), .err_count(ec_v[0]),
        .first_err_vld(vld_v[0]), .first_err_vec(vec_v[0]));

    alu_sweep_checker #(.SETTLE_CYCLES(2), .STOP_ON_ERR(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .alu(alu1.master),
        .busy(busy_v[1]), .done(done_v[1]), .err_count(ec_v[1]),
        .first_err_vld(vld_v[1]), .first_err_vec(vec_v[1]));

    alu_sweep_checker #(.SETTLE_CYCLES(0), .STOP_ON_ERR(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .alu(alu2.master),
        .busy(busy_v[2]), .done(done_v[2]), .err_count(ec_v[2]),
        .first_err_vld(vld_v[2]), .first_err_vec(vec_v[2]));

    // Reference ALU written with integer arithmetic.
    function automatic logic [3:0] alu_ref(input logic [3:0] x, input logic [1:0] s);
        int v;
        int r;
        case (s)
            2'd0: r = int'(x);
            2'd1: r = (16 - int'(x)) % 16;
            2'd2: begin
                v = (int'(x) >= 8) ? int'(x) - 16 : int'(x);
                r = v / 2;
            end
            default: r = int'(x) % 3;
        endcase
        return 4'(r);
    endfunction

    logic [3:0] r0, r1, r2;
    assign r0 = alu_ref({alu0.op_a, alu0.op_b, alu0.op_c, alu0.op_d}, {alu0.sel_s0, alu0.sel_s1});
    assign r1 = alu_ref({alu1.op_a, alu1.op_b, alu1.op_c, alu1.op_d}, {alu1.sel_s0, alu1.sel_s1});
    assign r2 = alu_ref({alu2.op_a, alu2.op_b, alu2.op_c, alu2.op_d}, {alu2.sel_s0, alu2.sel_s1});
    assign {alu0.res_a, alu0.res_b, alu0.res_c} = r0[3:1];
    assign {alu1.res_a, alu1.res_b, alu1.res_c} = r1[3:1];
    assign {alu2.res_a, alu2.res_b, alu2.res_c} = r2[3:1];
    assign alu0.res_d = r0[0] & ~fault;
    assign alu1.res_d = r1[0] & ~fault;
    assign alu2.res_d = r2[0] & ~fault;

    typedef struct {
        int inst;
        int start_cyc;
        int lat;
        int ec;
        int vld;
        int vec;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse retires the oldest expected sweep.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done_v[k]) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: inst %0d pulsed done with no sweep outstanding", k);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_inst",     k,                  e.inst);
                    chk("done_latency",  cyc - e.start_cyc,  e.lat);
                    chk("err_count",     int'(ec_v[k]),      e.ec);
                    chk("first_err_vld", int'(vld_v[k]),     e.vld);
                    chk("first_err_vec", int'(vec_v[k]),     e.vec);
                    chk("busy_at_done",  int'(busy_v[k]),    0);
                end
            end
        end
    end

    task automatic pulse_start(input int k, output int sc);
        @(negedge clk);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        sc = cyc;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: done not seen, %0d sweeps outstanding", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_sweep(input int k, input int lat, input int ec, input int vld, input int vec);
        int sc;
        exp_t e;
        pulse_start(k, sc);
        e = '{k, sc, lat, ec, vld, vec};
        sb.push_back(e);
        wait_drain();
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_busy"},  int'(busy_v[0]), 0);
        chk({tag, "_done"},  int'(done_v[0]), 0);
        chk({tag, "_ec"},    int'(ec_v[0]),   0);
        chk({tag, "_vld"},   int'(vld_v[0]),  0);
        chk({tag, "_vec"},   int'(vec_v[0]),  0);
        chk({tag, "_op"},    int'({alu0.op_a, alu0.op_b, alu0.op_c, alu0.op_d}), 0);
        chk({tag, "_sel"},   int'({alu0.sel_s0, alu0.sel_s1}), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int sc;
        exp_t e;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // T1: faulty sweep interrupted after 30 edges (vectors 1,3,5 already failed)
        fault = 1'b1;
        pulse_start(0, sc);
        repeat (30) @(negedge clk);
        chk("t1_busy_mid",  int'(busy_v[0]), 1);
        chk("t1_ec_mid",    int'(ec_v[0]),   3);
        chk("t1_vec_mid",   int'(vec_v[0]),  1);
        async_reset_check("t1_rst");

        // T2: clean sweep
        fault = 1'b0;
        run_sweep(0, 256, 0, 0, 0);

        // T3: res_d stuck at 0, then results hold after done
        fault = 1'b1;
        run_sweep(0, 256, 29, 1, 1);
        repeat (5) @(negedge clk);
        chk("t3_hold_ec",  int'(ec_v[0]),  29);
        chk("t3_hold_vld", int'(vld_v[0]), 1);
        chk("t3_hold_vec", int'(vec_v[0]), 1);

        // T4: stop on first error
        run_sweep(1, 8, 1, 1, 1);

        // T5: abort at vector 20, restart, start pulse while busy is ignored
        fault = 1'b0;
        pulse_start(0, sc);
        repeat (80) @(negedge clk);
        async_reset_check("t5_rst");
        pulse_start(0, sc);
        e = '{0, sc, 256, 0, 0, 0};
        sb.push_back(e);
        repeat (10) @(negedge clk);
        pulse_start(0, sc);
        wait_drain();

        // T6: zero settle window
        run_sweep(2, 128, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
